fetch_unpacker: RTL and testbench
=================================

Name: fetch_unpacker

Overview:
- Sits directly downstream of the fetch-queue FIFO, between the fetch queue and decode.
- Pops one fetch packet from the FIFO sender side. A packet holds up to FETCH_WIDTH instructions plus a valid mask.
- Holds the packet and issues up to DECODE_WIDTH instructions per cycle to decode, compacted lowest-slot-first.
- Pops the next packet only once every valid slot of the current one has been issued.

Parameters:
- FETCH_WIDTH, 4, instruction slots per fetch packet (power of 2, >= DECODE_WIDTH).
- DECODE_WIDTH, 2, instructions issued per cycle (1..FETCH_WIDTH).
- INST_WIDTH, 32, instruction word width.
- PC_WIDTH, 32, PC width; PC stride is 4 bytes per slot.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: synchronous, active-low.
- flush  in  1  pipeline flush; discards the held packet.
- in_valid  in  1  packet valid from FIFO sender.
- in_ready  out  1  packet accept to FIFO sender.
- in_pc  in  PC_WIDTH  PC of slot 0 (packet-aligned).
- in_inst  in  FETCH_WIDTH*INST_WIDTH  slot i at bits [i*INST_WIDTH +: INST_WIDTH].
- in_mask  in  FETCH_WIDTH  per-slot valid.
- out_valid  out  1  decode group valid.
- out_ready  in  1  decode accepts the group.
- out_inst  out  DECODE_WIDTH*INST_WIDTH  compacted instructions, lane 0 = oldest.
- out_pc  out  DECODE_WIDTH*PC_WIDTH  per-lane PC.
- out_mask  out  DECODE_WIDTH  per-lane valid; always contiguous from lane 0.
- perf_issue_cnt  out  32  instructions issued (optional feature).
- perf_stall_cnt  out  32  cycles with out_valid & !out_ready (optional feature).

Behaviour:
- State: hold_valid, hold_pc, hold_inst, hold_mask (remaining slots).
- Reset while rst_n low, applied at the clock edge:
  - hold_valid=0, hold_mask=0, hold_pc/hold_inst=0.
  - Outputs: out_valid=0, out_mask=0, out_inst/out_pc=0, in_ready=0, perf counters=0.
  - in_ready is gated low while rst_n=0.
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - out_valid, out_inst, out_pc and out_mask must stay stable while out_valid & !out_ready.
- Selection:
  - pick = first min(DECODE_WIDTH, popcount(hold_mask)) set bits of hold_mask, in ascending slot order.
  - Lane k gets slot s_k.
  - out_pc[k] = hold_pc + 4*s_k, computed modulo 2^PC_WIDTH.
  - Unused lanes: mask 0, inst/pc 0.
- out_valid = hold_valid & !flush.
- last = (hold_mask & ~pick) == 0.
- in_ready = rst_n & !flush & (!hold_valid | (out_fire & last)).
  - Combinational from out_ready is permitted; no same-cycle path from in_valid to out_*.
- Register update, priority top-down:
  - flush: hold_valid=0, hold_mask=0.
  - in_fire with in_mask!=0: load in_pc/in_inst/in_mask; hold_valid=1.
  - in_fire with in_mask==0: packet consumed and dropped; hold_valid=0.
  - out_fire & !last: hold_mask &= ~pick.
  - out_fire & last & !in_fire: hold_valid=0, hold_mask=0.
- Latency: packet accepted at edge T is visible on out_* in cycle T+1.
  - Back-to-back gives full throughput: a last issue and the next accept happen in the same cycle.
- Boundary cases:
  - Sparse mask (e.g. 4'b1010) compacts to lanes 0,1.
  - FETCH_WIDTH==DECODE_WIDTH: every packet issues in one cycle.
  - Flush with in_valid high: nothing accepted that cycle.
  - Reset mid-packet: remaining slots lost, no output in the cycle after reset release.

Optional Feature:
- FETCH_UNPACKER_PERF_EN defined:
  - perf_issue_cnt += popcount(out_mask) on out_fire.
  - perf_stall_cnt += 1 on out_valid & !out_ready.
  - Both are 32-bit, wrap at 2^32, not cleared by flush, cleared by reset.
- Undefined: both ports tied to 0, no counter flops.

Decomposition:
- Shared package: FETCH_WIDTH/DECODE_WIDTH/INST_WIDTH constants and a fetch_pkt_t struct {pc, inst[FETCH_WIDTH], mask}, so the FIFO can be instantiated with T = fetch_pkt_t.
- One sub-module, mask_pick_first, combinational:
  - Input: FETCH_WIDTH mask.
  - Outputs: DECODE_WIDTH slot indices, lane-valid vector, and the pick mask.

Test Plan:
- Reset, then in_valid=1, in_pc=0x1C000000, in_mask=4'b1111, out_ready=1 -> cycle+1 out_pc lanes {0x1C000000,0x1C000004}, out_mask 2'b11; cycle+2 {0x1C000008,0x1C00000C}; in_ready=1 in cycle+2, next packet accepted same cycle.
- in_mask=4'b1010, in_pc=0x100 -> single group: out_pc {0x104,0x10C}, out_mask 2'b11, in_ready=1 that cycle.
- in_mask=4'b0100 -> out_mask 2'b01, out_pc lane0=0x108; in_mask=4'b0000 accepted, never appears on output.
- out_ready=0 for 5 cycles with group valid -> out_* stable, in_ready=0; with PERF_EN, perf_stall_cnt=5.
- flush asserted while holding 2 remaining slots and in_valid=1 -> out_valid=0 and in_ready=0 that cycle; next cycle hold empty, in_ready=1.
- rst_n low for 1 cycle mid-packet -> out_valid=0, in_ready=0 during reset; after release in_ready=1, no stale slots emitted.

Source files
------------

// File: rtl/fetch_unpacker_pkg.sv
// rtl/fetch_unpacker_pkg.sv - shared widths and fetch packet type for the fetch unpacker
package fetch_unpacker_pkg;

    localparam int FETCH_WIDTH  = 4;
    localparam int DECODE_WIDTH = 2;
    localparam int INST_WIDTH   = 32;
    localparam int PC_WIDTH     = 32;

    // Packet layout as stored in the fetch-queue FIFO
    typedef struct packed {
        logic [PC_WIDTH-1:0]                        pc;
        logic [FETCH_WIDTH-1:0][INST_WIDTH-1:0]     inst;
        logic [FETCH_WIDTH-1:0]                     mask;
    } fetch_pkt_t;

    function automatic int slot_bits(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/fetch_unpacker_mask_pick_first.sv
// rtl/fetch_unpacker_mask_pick_first.sv - selects the lowest DECODE_WIDTH set bits of a slot mask
module mask_pick_first
    import fetch_unpacker_pkg::*;
#(
    parameter int FETCH_WIDTH  = fetch_unpacker_pkg::FETCH_WIDTH,
    parameter int DECODE_WIDTH = fetch_unpacker_pkg::DECODE_WIDTH,
    parameter int SLOT_W       = slot_bits(FETCH_WIDTH)
) (
    input  logic [FETCH_WIDTH-1:0]          mask_i,
    output logic [DECODE_WIDTH*SLOT_W-1:0]  slot_idx_o,
    output logic [DECODE_WIDTH-1:0]         lane_valid_o,
    output logic [FETCH_WIDTH-1:0]          pick_o
);

    logic [FETCH_WIDTH-1:0] rem;
    logic                   found;

    // Each lane claims the lowest remaining set bit, so lanes fill contiguously from lane 0
    always_comb begin
        rem          = mask_i;
        slot_idx_o   = '0;
        lane_valid_o = '0;
        pick_o       = '0;
        found        = 1'b0;
        for (int k = 0; k < DECODE_WIDTH; k++) begin
            found = 1'b0;
            for (int s = 0; s < FETCH_WIDTH; s++) begin
                if (!found && rem[s]) begin
                    found                         = 1'b1;
                    slot_idx_o[k*SLOT_W +: SLOT_W] = SLOT_W'(s);
                    lane_valid_o[k]               = 1'b1;
                    pick_o[s]                     = 1'b1;
                    rem[s]                        = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/fetch_unpacker.sv
// rtl/fetch_unpacker.sv - splits fetch packets into decode groups; perf counters under FETCH_UNPACKER_PERF_EN
module fetch_unpacker
    import fetch_unpacker_pkg::*;
#(
    parameter int FETCH_WIDTH  = fetch_unpacker_pkg::FETCH_WIDTH,
    parameter int DECODE_WIDTH = fetch_unpacker_pkg::DECODE_WIDTH,
    parameter int INST_WIDTH   = fetch_unpacker_pkg::INST_WIDTH,
    parameter int PC_WIDTH     = fetch_unpacker_pkg::PC_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [PC_WIDTH-1:0]              in_pc,
    input  logic [FETCH_WIDTH*INST_WIDTH-1:0] in_inst,
    input  logic [FETCH_WIDTH-1:0]           in_mask,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DECODE_WIDTH*INST_WIDTH-1:0] out_inst,
    output logic [DECODE_WIDTH*PC_WIDTH-1:0] out_pc,
    output logic [DECODE_WIDTH-1:0]          out_mask,
    output logic [31:0]                      perf_issue_cnt,
    output logic [31:0]                      perf_stall_cnt
);

    localparam int SLOT_W = slot_bits(FETCH_WIDTH);

    logic                              hold_valid_q, hold_valid_d;
    logic [PC_WIDTH-1:0]               hold_pc_q, hold_pc_d;
    logic [FETCH_WIDTH*INST_WIDTH-1:0] hold_inst_q, hold_inst_d;
    logic [FETCH_WIDTH-1:0]            hold_mask_q, hold_mask_d;

    logic [DECODE_WIDTH*SLOT_W-1:0]    slot_idx;
    logic [DECODE_WIDTH-1:0]           lane_valid;
    logic [FETCH_WIDTH-1:0]            pick;
    logic                              last;
    logic                              in_fire;
    logic                              out_fire;

    mask_pick_first #(
        .FETCH_WIDTH  (FETCH_WIDTH),
        .DECODE_WIDTH (DECODE_WIDTH),
        .SLOT_W       (SLOT_W)
    ) u_pick (
        .mask_i       (hold_mask_q),
        .slot_idx_o   (slot_idx),
        .lane_valid_o (lane_valid),
        .pick_o       (pick)
    );

    assign last      = (hold_mask_q & ~pick) == '0;
    assign out_valid = hold_valid_q & rst_n & !flush;
    assign out_fire  = out_valid & out_ready;
    // Accept the next packet in the same cycle the last group leaves, for full throughput
    assign in_ready  = rst_n & !flush & (!hold_valid_q | (out_fire & last));
    assign in_fire   = in_valid & in_ready;

    always_comb begin
        out_inst = '0;
        out_pc   = '0;
        out_mask = '0;
        if (out_valid) begin
            for (int k = 0; k < DECODE_WIDTH; k++) begin
                if (lane_valid[k]) begin
                    out_mask[k] = 1'b1;
                    out_pc[k*PC_WIDTH +: PC_WIDTH] =
                        hold_pc_q + (PC_WIDTH'(slot_idx[k*SLOT_W +: SLOT_W]) << 2);
                    for (int s = 0; s < FETCH_WIDTH; s++) begin
                        if (slot_idx[k*SLOT_W +: SLOT_W] == SLOT_W'(s)) begin
                            out_inst[k*INST_WIDTH +: INST_WIDTH] =
                                hold_inst_q[s*INST_WIDTH +: INST_WIDTH];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_pc_d    = hold_pc_q;
        hold_inst_d  = hold_inst_q;
        hold_mask_d  = hold_mask_q;
        if (flush) begin
            hold_valid_d = 1'b0;
            hold_mask_d  = '0;
        end else if (in_fire) begin
            if (in_mask != '0) begin
                hold_valid_d = 1'b1;
                hold_pc_d    = in_pc;
                hold_inst_d  = in_inst;
                hold_mask_d  = in_mask;
            end else begin
                hold_valid_d = 1'b0;
                hold_mask_d  = '0;
            end
        end else if (out_fire && !last) begin
            hold_mask_d = hold_mask_q & ~pick;
        end else if (out_fire) begin
            hold_valid_d = 1'b0;
            hold_mask_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_valid_q <= 1'b0;
            hold_pc_q    <= '0;
            hold_inst_q  <= '0;
            hold_mask_q  <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_pc_q    <= hold_pc_d;
            hold_inst_q  <= hold_inst_d;
            hold_mask_q  <= hold_mask_d;
        end
    end

`ifdef FETCH_UNPACKER_PERF_EN
    logic [31:0] issue_cnt_q;
    logic [31:0] stall_cnt_q;

    // Counters survive flush so they reflect whole-run activity
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (out_fire) begin
                issue_cnt_q <= issue_cnt_q + 32'($countones(out_mask));
            end
            if (out_valid && !out_ready) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_issue_cnt = issue_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    assign perf_issue_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_unpacker.sv
// tb/tb_fetch_unpacker.sv - scoreboard bench for fetch_unpacker
module tb_fetch_unpacker;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_pc;
    logic [127:0] in_inst;
    logic [3:0]   in_mask;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_inst;
    logic [63:0]  out_pc;
    logic [1:0]   out_mask;
    logic [31:0]  perf_issue_cnt;
    logic [31:0]  perf_stall_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] inst;
        logic [1:0]  mask;
    } grp_t;

    grp_t exp_q[$];

    fetch_unpacker dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_inst        (in_inst),
        .in_mask        (in_mask),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_mask       (out_mask),
        .perf_issue_cnt (perf_issue_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc1, input logic [31:0] pc0,
                        input logic [31:0] i1, input logic [31:0] i0, input logic [1:0] m);
        grp_t g;
        g.pc   = {pc1, pc0};
        g.inst = {i1, i0};
        g.mask = m;
        exp_q.push_back(g);
    endtask

    // Present a packet and hold it until accepted; reports cycles spent waiting for in_ready
    task automatic send(input logic [31:0] pc, input logic [3:0] m, input logic [31:0] base,
                        output int waits);
        in_valid = 1'b1;
        in_pc    = pc;
        in_mask  = m;
        in_inst  = {base + 32'd3, base + 32'd2, base + 32'd1, base};
        waits    = 0;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            failures++;
            $display("FAIL send_timeout pc=%h", pc);
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_group actual_pc=%h actual_mask=%b", out_pc, out_mask);
            end else begin
                grp_t g;
                g = exp_q.pop_front();
                chk("grp_pc",   out_pc,   g.pc);
                chk("grp_inst", out_inst, g.inst);
                chk("grp_mask", {62'd0, out_mask}, {62'd0, g.mask});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [63:0] snap_pc, snap_inst;
        logic [1:0]  snap_mask;
        logic [31:0] exp_stall, exp_issue;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0;
        in_mask = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready",  {63'd0, in_ready},  64'd0);
        chk("rst_out_mask",  {62'd0, out_mask},  64'd0);
        chk("rst_out_pc",    out_pc,   64'd0);
        chk("rst_out_inst",  out_inst, 64'd0);
        chk("rst_perf_issue", {32'd0, perf_issue_cnt}, 64'd0);
        chk("rst_perf_stall", {32'd0, perf_stall_cnt}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Full packet: two groups, then back-to-back accept on the last group
        push(32'h1C000004, 32'h1C000000, 32'hA0000001, 32'hA0000000, 2'b11);
        push(32'h1C00000C, 32'h1C000008, 32'hA0000003, 32'hA0000002, 2'b11);
        send(32'h1C000000, 4'b1111, 32'hA0000000, w);
        chk("a_waits", 64'(w), 64'd0);
        push(32'h0000010C, 32'h00000104, 32'hB0000003, 32'hB0000001, 2'b11);
        send(32'h00000100, 4'b1010, 32'hB0000000, w);
        chk("b_waits_same_cycle", 64'(w), 64'd1);

        // Sparse single-group packets and an empty packet
        push(32'h00000000, 32'h00000208, 32'h00000000, 32'hC0000002, 2'b01);
        send(32'h00000200, 4'b0100, 32'hC0000000, w);
        chk("c_waits", 64'(w), 64'd0);
        send(32'h00000300, 4'b0000, 32'hD0000000, w);
        chk("d_waits", 64'(w), 64'd0);
        push(32'h00000404, 32'h00000400, 32'hE0000001, 32'hE0000000, 2'b11);
        send(32'h00000400, 4'b0011, 32'hE0000000, w);
        chk("e_waits", 64'(w), 64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Backpressure: group stays stable for 5 cycles
        @(negedge clk);
        snap_pc = out_pc; snap_inst = out_inst; snap_mask = out_mask;
        chk("stall_valid", {63'd0, out_valid}, 64'd1);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            chk("stall_pc_stable",   out_pc,   snap_pc);
            chk("stall_inst_stable", out_inst, snap_inst);
            chk("stall_mask_stable", {62'd0, out_mask}, {62'd0, snap_mask});
            chk("stall_in_ready",    {63'd0, in_ready}, 64'd0);
            chk("stall_valid_hold",  {63'd0, out_valid}, 64'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
`ifdef FETCH_UNPACKER_PERF_EN
        exp_stall = 32'd5;
        exp_issue = 32'd7;
`else
        exp_stall = 32'd0;
        exp_issue = 32'd0;
`endif
        chk("perf_stall", {32'd0, perf_stall_cnt}, {32'd0, exp_stall});
        chk("perf_issue", {32'd0, perf_issue_cnt}, {32'd0, exp_issue});
        @(posedge clk); #1;

        // Flush with two slots left and a new packet waiting
        push(32'h00000504, 32'h00000500, 32'hF0000001, 32'hF0000000, 2'b11);
        send(32'h00000500, 4'b1111, 32'hF0000000, w);
        in_pc = 32'h00000600; in_mask = 4'b0001;
        in_inst = {32'h66000003, 32'h66000002, 32'h66000001, 32'h66000000};
        @(negedge clk);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_in_ready",  {63'd0, in_ready},  64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        push(32'h00000000, 32'h00000600, 32'h00000000, 32'h66000000, 2'b01);
        @(negedge clk);
        chk("post_flush_in_ready",  {63'd0, in_ready},  64'd1);
        chk("post_flush_out_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;

        // Reset mid-packet drops the remaining slots
        push(32'h00000704, 32'h00000700, 32'h77000001, 32'h77000000, 2'b11);
        send(32'h00000700, 4'b1111, 32'h77000000, w);
        in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_in_ready",  {63'd0, in_ready},  64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("after_rst_in_ready",  {63'd0, in_ready},  64'd1);
        chk("after_rst_perf_issue", {32'd0, perf_issue_cnt}, 64'd0);
        repeat (3) @(negedge clk);
        chk("after_rst_no_output", {63'd0, out_valid}, 64'd0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
